// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared core parameters and fetch FSM encoding
package ifetch_pkg;

  localparam int CORE_XLEN      = 32;
  localparam int CORE_BUF_DEPTH = 2;

  // IDLE: nothing outstanding, WAIT: one outstanding, DROP: one outstanding whose data is stale
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_fetch_buf.sv
// rtl/ifetch_fetch_buf.sv - synchronous instruction FIFO with clear
module fetch_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // a push into a full buffer is accepted only when the head leaves the same cycle
  assign do_push = push & (~full | do_pop);

  // storage, pointers and occupancy; clear drops every entry on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with single outstanding request
module ifetch
  import ifetch_pkg::*;
#(
  parameter int XLEN      = CORE_XLEN,
  parameter int BUF_DEPTH = CORE_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_stall,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  fetch_state_t    state;
  logic [XLEN-1:0] inflight_pc;
  logic            buf_full;
  logic            buf_empty;
  logic            buf_push;
  logic            buf_pop;
  logic [2*XLEN-1:0] buf_head;

  // masking instead of slicing keeps every pc_addr bit in use
  assign imem_addr = pc_addr & {{(XLEN-2){1'b1}}, 2'b00};
  assign imem_req  = rst_n & ~flush & (state == ST_IDLE) & ~buf_full;
  assign pc_stall  = ~(imem_req & imem_ready);

  assign buf_push = (state == ST_WAIT) & imem_rvalid & ~flush;
  assign buf_pop  = id_valid & id_ready;

  assign id_valid = ~buf_empty;
  assign id_pc    = buf_head[2*XLEN-1:XLEN];
  assign id_instr = buf_head[XLEN-1:0];

  // request/response tracking; a returning response always frees the slot, even in DROP under flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      inflight_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (imem_req && imem_ready) begin
            state       <= ST_WAIT;
            inflight_pc <= imem_addr;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_IDLE;
          end else if (flush) begin
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_buf #(
    .WIDTH (2 * XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (buf_pop),
    .clear     (flush),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for the fetch stage
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_stall    (pc_stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_addr = 32'h100; imem_ready = 1'b1; id_ready = 1'b0;
    sbq.delete();
    tick(); tick();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%0b exp=1", pc_stall); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%0b exp=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL rst_id_instr got=%h exp=0", id_instr); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
    imem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    pc_addr = 32'h0; imem_ready = 1'b1; id_ready = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL single_req got=%0b exp=1", imem_req); end
    total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL single_stall_low got=%0b exp=0", pc_stall); end
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
    sbq.push_back('{pc: 32'h0, instr: 32'h00000013});
    #1;
    total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL single_stall_after got=%0b exp=1", pc_stall); end
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", id_valid); end
    id_ready = 1'b1;
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL single_sb_empty got=0 exp=1"); end
    else begin
      e = sbq.pop_front();
      if ({id_pc, id_instr} !== {e.pc, e.instr}) begin
        bad++; $display("FAIL single_head got=%h/%h exp=%h/%h", id_pc, id_instr, e.pc, e.instr);
      end
    end
    tick();
    id_ready = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b exp=0", id_valid); end
  endtask

  task automatic test_full();
    exp_t e;
    id_ready = 1'b0; pc_addr = 32'h0; imem_ready = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hAAAA0001; pc_addr = 32'h4;
    sbq.push_back('{pc: 32'h0, instr: 32'hAAAA0001});
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL full_second_req got=%0b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL full_second_addr got=%h exp=4", imem_addr); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB0002; pc_addr = 32'h8;
    sbq.push_back('{pc: 32'h4, instr: 32'hBBBB0002});
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req_held got=%0b exp=0", imem_req); end
      total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%0b exp=1", pc_stall); end
      tick();
    end
    imem_ready = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (sbq.size() == 0) begin bad++; $display("FAIL full_sb_empty got=0 exp=1"); end
      else begin
        e = sbq.pop_front();
        if ({id_valid, id_pc, id_instr} !== {1'b1, e.pc, e.instr}) begin
          bad++; $display("FAIL full_pop_order got=%0b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
    end
    id_ready = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b exp=0", id_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL full_req_resume got=%0b exp=1", imem_req); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    id_ready = 1'b0; pc_addr = 32'h40; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC0DE0040;
    sbq.push_back('{pc: 32'h40, instr: 32'hC0DE0040});
    tick();
    imem_rvalid = 1'b0; pc_addr = 32'h44; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC0DE0044; id_ready = 1'b1;
    sbq.push_back('{pc: 32'h44, instr: 32'hC0DE0044});
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (sbq.size() == 0) begin bad++; $display("FAIL b2b_sb_empty got=0 exp=1"); end
      else begin
        e = sbq.pop_front();
        if ({id_valid, id_pc, id_instr} !== {1'b1, e.pc, e.instr}) begin
          bad++; $display("FAIL b2b_head got=%0b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, e.pc, e.instr);
        end
      end
      tick();
      imem_rvalid = 1'b0;
    end
    id_ready = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b exp=0", id_valid); end
  endtask

  task automatic test_flush_inflight();
    id_ready = 1'b0; pc_addr = 32'h30; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h11110030;
    sbq.push_back('{pc: 32'h30, instr: 32'h11110030});
    tick();
    imem_rvalid = 1'b0; pc_addr = 32'h8; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; flush = 1'b1;
    sbq.delete();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL flush_req got=%0b exp=0", imem_req); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_buf_cleared got=%0b exp=0", id_valid); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL drop_req got=%0b exp=0", imem_req); end
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL drop_discard got=%0b exp=0", id_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL drop_to_idle got=%0b exp=1", imem_req); end
  endtask

  task automatic test_flush_rvalid();
    exp_t e;
    id_ready = 1'b0; pc_addr = 32'h10; imem_ready = 1'b1;
    tick();
    flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD00010; pc_addr = 32'd80;
    tick();
    flush = 1'b0; imem_rvalid = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flushrv_nopush got=%0b exp=0", id_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL flushrv_req got=%0b exp=1", imem_req); end
    total++; if (imem_addr !== 32'd80) begin bad++; $display("FAIL flushrv_addr got=%0d exp=80", imem_addr); end
    total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL flushrv_stall got=%0b exp=0", pc_stall); end
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
    sbq.push_back('{pc: 32'd80, instr: 32'h00500093});
    tick();
    imem_rvalid = 1'b0; id_ready = 1'b1;
    #1;
    total++;
    if (sbq.size() == 0) begin bad++; $display("FAIL flushrv_sb_empty got=0 exp=1"); end
    else begin
      e = sbq.pop_front();
      if ({id_valid, id_pc, id_instr} !== {1'b1, e.pc, e.instr}) begin
        bad++; $display("FAIL flushrv_head got=%0b/%h/%h exp=1/%h/%h", id_valid, id_pc, id_instr, e.pc, e.instr);
      end
    end
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_align();
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    addrs[0] = 32'd21;        exps[0] = 32'd20;
    addrs[1] = 32'hFFFFFFFF;  exps[1] = 32'hFFFFFFFC;
    addrs[2] = 32'h00001006;  exps[2] = 32'h00001004;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_addr = addrs[i];
      #1;
      total++; if (imem_addr !== exps[i]) begin bad++; $display("FAIL align got=%h exp=%h", imem_addr, exps[i]); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pc_addr = 32'h60; imem_ready = 1'b1; id_ready = 1'b0;
    tick();
    imem_ready = 1'b0; rst_n = 1'b0;
    sbq.delete();
    tick();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%0b exp=0", imem_req); end
    total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL rstmid_stall got=%0b exp=1", pc_stall); end
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hFEEDF00D;
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rstmid_late got=%0b exp=0", id_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%0b exp=1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush_inflight();
    test_flush_rvalid();
    test_align();
    test_reset_mid();
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pc_addr  input  XLEN  current fetch address from pc stage.
REQ-006 SHALL have port pc_stall  output  1  holds pc stage; low only in cycles a request is accepted.
REQ-007 SHALL have port flush  input  1  redirect or fault; discards in-flight and buffered fetches.
REQ-008 SHALL have port imem_req  output  1  memory request valid.
REQ-009 SHALL have port imem_addr  output  XLEN  word-aligned request address.
REQ-010 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  response data valid.
REQ-012 SHALL have port imem_rdata  input  XLEN  response instruction word.
REQ-013 SHALL have port id_valid  output  1  buffer head valid to decode.
REQ-014 SHALL have port id_instr  output  XLEN  buffer head instruction.
REQ-015 SHALL have port id_pc  output  XLEN  address of buffer head instruction.
REQ-016 SHALL have port id_ready  input  1  decode consumes head when id_valid high.

Function
REQ-017 SHALL implement FSM states IDLE (none outstanding), WAIT (one outstanding), DROP (one outstanding, response to be discarded).
REQ-018 SHALL drive imem_addr = {pc_addr[XLEN-1:2], 2'b00} combinationally.
REQ-019 SHALL assert imem_req only when rst_n high, flush low, state IDLE, and buffer occupancy < BUF_DEPTH.
REQ-020 SHALL count a request accepted when imem_req and imem_ready both high; IDLE -> WAIT, latching imem_addr as the in-flight pc.
REQ-021 SHALL drive pc_stall = ~(imem_req & imem_ready), so the pc advances exactly once per accepted request.
REQ-022 SHALL, in WAIT with imem_rvalid high and flush low, push {in-flight pc, imem_rdata} and go to IDLE; entry visible on id_* next cycle (1-cycle response-to-decode latency).
REQ-023 SHALL allow a new request in the same cycle a WAIT response returns only from the next cycle (at most one outstanding request).
REQ-024 SHALL pop the head when id_valid & id_ready; push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-025 SHALL, on flush, empty the buffer the same edge, drop id_valid next cycle, and move WAIT -> DROP (or stay IDLE).
REQ-026 SHALL, on flush coinciding with imem_rvalid in WAIT, discard the response and go to IDLE.
REQ-027 SHALL, in DROP, discard the response on imem_rvalid and go to IDLE; a flush in DROP keeps DROP.
REQ-028 SHALL ignore imem_rvalid in IDLE.
REQ-029 SHALL keep id_instr/id_pc stable while id_valid high and id_ready low.

Reset
REQ-030 SHALL, when rst_n low at a rising edge, set state IDLE, buffer empty, in-flight pc 0; id_valid 0, id_instr 0, id_pc 0.
REQ-031 SHALL hold imem_req 0 and pc_stall 1 while rst_n low; reset mid-transaction abandons the outstanding request (its late response ignored per REQ-028).

Structure
REQ-032 SHALL take XLEN, BUF_DEPTH and the FSM state encoding from the shared core package.
REQ-033 SHALL implement the buffer as sub-module fetch_buf (synchronous FIFO with push, pop, clear, full, empty).

Verification
REQ-034 Reset then pc_addr=0, imem_ready=1, response 1 cycle later with 0x00000013 -> id_valid=1, id_pc=0, id_instr=0x00000013; pc_stall low exactly one cycle.
REQ-035 id_ready=0, back-to-back responses at pc 0,4 -> buffer full, imem_req=0, pc_stall=1 until a pop; pop order pc 0 then 4.
REQ-036 Request at pc 8 accepted, flush next cycle, response arrives 2 cycles later -> discarded, id_valid stays 0, state returns IDLE.
REQ-037 flush and imem_rvalid same cycle in WAIT -> no push, next request issued following cycle at new pc_addr=80.
REQ-038 pc_addr=21 -> imem_addr=20.
REQ-039 rst_n low during WAIT, late imem_rvalid after release -> ignored, id_valid=0.
